// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing with Colpx/Rowpx counters and registered syncs.
// Optional: define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on by two clocks.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       vga_clock,
    input  logic       reset,
    output logic [9:0] Colpx,
    output logic [9:0] Rowpx,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic       L_ACT  = (SYNC_POL != 0);

    logic [9:0] r_col;
    logic [9:0] r_row;
    logic       r_run;
    logic       r_hs;
    logic       r_vs;
    logic       r_de;
    logic       r_ft;

    logic [9:0] w_col_nxt;
    logic [9:0] w_row_nxt;
    logic       w_hs;
    logic       w_vs;
    logic       w_de;
    logic       w_ft;

    // Next counter state; r_run holds (0,0) for the first clock after reset
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (r_run) begin
            if (r_col == H_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row == V_LAST) ? '0 : r_row + 10'd1;
            end else begin
                w_col_nxt = r_col + 10'd1;
            end
        end
    end

    // Decode outputs from the next-state counters so they land with them
    always_comb begin
        w_hs = ((w_col_nxt >= HS_BEG) && (w_col_nxt < HS_END)) ? L_ACT : ~L_ACT;
        w_vs = ((w_row_nxt >= VS_BEG) && (w_row_nxt < VS_END)) ? L_ACT : ~L_ACT;
        w_de = (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);
        w_ft = (w_col_nxt == 10'd0) && (w_row_nxt == V_VIS);
    end

    // Counter and aligned output registers
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
            r_run <= 1'b0;
            r_hs  <= ~L_ACT;
            r_vs  <= ~L_ACT;
            r_de  <= 1'b0;
            r_ft  <= 1'b0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            r_run <= 1'b1;
            r_hs  <= w_hs;
            r_vs  <= w_vs;
            r_de  <= w_de;
            r_ft  <= w_ft;
        end
    end

    assign Colpx      = r_col;
    assign Rowpx      = r_row;
    assign frame_tick = r_ft;

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] r_hs_dly;
    logic [1:0] r_vs_dly;
    logic [1:0] r_de_dly;

    // Two extra stages to match the icon overlay pipeline
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_hs_dly <= {2{~L_ACT}};
            r_vs_dly <= {2{~L_ACT}};
            r_de_dly <= 2'b00;
        end else begin
            r_hs_dly <= {r_hs_dly[0], r_hs};
            r_vs_dly <= {r_vs_dly[0], r_vs};
            r_de_dly <= {r_de_dly[0], r_de};
        end
    end

    assign hsync    = r_hs_dly[1];
    assign vsync    = r_vs_dly[1];
    assign video_on = r_de_dly[1];
`else
    assign hsync    = r_hs;
    assign vsync    = r_vs;
    assign video_on = r_de;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-size instance for line timing, shrunken instance
// for frame timing, both scoreboarded every clock against a timing model.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [9:0] col_a, row_a, col_b, row_b;
    logic       hs_a, vs_a, de_a, ft_a;
    logic       hs_b, vs_b, de_b, ft_b;

    always #20 clk = ~clk;

    vga_timing_gen u_a (
        .vga_clock (clk),
        .reset     (rst_a),
        .Colpx     (col_a),
        .Rowpx     (row_a),
        .hsync     (hs_a),
        .vsync     (vs_a),
        .video_on  (de_a),
        .frame_tick(ft_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL (0)
    ) u_b (
        .vga_clock (clk),
        .reset     (rst_b),
        .Colpx     (col_b),
        .Rowpx     (row_b),
        .hsync     (hs_b),
        .vsync     (vs_b),
        .video_on  (de_b),
        .frame_tick(ft_b)
    );

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ft;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_assert = 0;
    int n_fail   = 0;

    int HV[2] = '{640, 16};
    int HF[2] = '{16, 2};
    int HS[2] = '{96, 4};
    int HB[2] = '{48, 3};
    int VV[2] = '{480, 12};
    int VF[2] = '{10, 2};
    int VS[2] = '{2, 2};
    int VB[2] = '{33, 3};

    int       m_col[2];
    int       m_row[2];
    bit       m_run[2];
    logic [2:0] p_hs[2];
    logic [2:0] p_vs[2];
    logic [2:0] p_de[2];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int i, input logic rst, output exp_t e);
        int   ht, vt, c, r;
        logic hs_r, vs_r, de_r, ft_r;
        ht = HV[i] + HF[i] + HS[i] + HB[i];
        vt = VV[i] + VF[i] + VS[i] + VB[i];
        ft_r = 1'b0;
        if (rst) begin
            m_col[i] = 0;
            m_row[i] = 0;
            m_run[i] = 1'b0;
            p_hs[i]  = 3'b111;
            p_vs[i]  = 3'b111;
            p_de[i]  = 3'b000;
        end else begin
            if (m_run[i]) begin
                m_col[i]++;
                if (m_col[i] == ht) begin
                    m_col[i] = 0;
                    m_row[i]++;
                    if (m_row[i] == vt) m_row[i] = 0;
                end
            end else begin
                m_run[i] = 1'b1;
            end
            c = m_col[i];
            r = m_row[i];
            hs_r = !((c >= HV[i] + HF[i]) && (c < HV[i] + HF[i] + HS[i]));
            vs_r = !((r >= VV[i] + VF[i]) && (r < VV[i] + VF[i] + VS[i]));
            de_r = (c < HV[i]) && (r < VV[i]);
            ft_r = (c == 0) && (r == VV[i]);
            p_hs[i] = {p_hs[i][1:0], hs_r};
            p_vs[i] = {p_vs[i][1:0], vs_r};
            p_de[i] = {p_de[i][1:0], de_r};
        end
        e.col = 10'(m_col[i]);
        e.row = 10'(m_row[i]);
        e.hs  = DLY ? p_hs[i][2] : p_hs[i][0];
        e.vs  = DLY ? p_vs[i][2] : p_vs[i][0];
        e.de  = DLY ? p_de[i][2] : p_de[i][0];
        e.ft  = ft_r;
    endtask

    task automatic cycle();
        exp_t ea, eb;
        model(0, rst_a, ea);
        q0.push_back(ea);
        model(1, rst_b, eb);
        q1.push_back(eb);
        @(posedge clk);
        #1;
        ea = q0.pop_front();
        eb = q1.pop_front();
        chk10("a.Colpx", col_a, ea.col);
        chk10("a.Rowpx", row_a, ea.row);
        chk1("a.hsync", hs_a, ea.hs);
        chk1("a.vsync", vs_a, ea.vs);
        chk1("a.video_on", de_a, ea.de);
        chk1("a.frame_tick", ft_a, ea.ft);
        chk10("b.Colpx", col_b, eb.col);
        chk10("b.Rowpx", row_b, eb.row);
        chk1("b.hsync", hs_b, eb.hs);
        chk1("b.vsync", vs_b, eb.vs);
        chk1("b.video_on", de_b, eb.de);
        chk1("b.frame_tick", ft_b, eb.ft);
    endtask

    initial begin
        int   h_low, h_first, v_on, v_first;
        int   v_low, v_fst, v_row, ft_n, ft_idx, wrap_idx;
        int   pc, pr, wpc, wpr;
        logic ftc_ok, wde;
        logic [9:0] ftc, ftr;
        bit   found;

        h_low = 0; h_first = -1; v_on = 0; v_first = -1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) cycle();
        chk10("rst.Colpx", col_a, 10'd0);
        chk10("rst.Rowpx", row_a, 10'd0);
        chk1("rst.hsync", hs_a, 1'b1);
        chk1("rst.vsync", vs_a, 1'b1);
        chk1("rst.video_on", de_a, 1'b0);
        chk1("rst.frame_tick", ft_a, 1'b0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        cycle();
        chk10("first.Colpx", col_a, 10'd0);
        chk10("first.Rowpx", row_a, 10'd0);
        chk1("first.video_on", de_a, DLY ? 1'b0 : 1'b1);
        chk1("first.hsync", hs_a, 1'b1);
        chk1("first.vsync", vs_a, 1'b1);

        for (int k = 0; k < 800; k++) begin
            if (k > 0) cycle();
            if (!hs_a) begin
                if (h_first < 0) h_first = int'(col_a);
                h_low++;
            end
            if (de_a) begin
                if (v_first < 0) v_first = int'(col_a);
                v_on++;
            end
        end
        chk10("line.Colpx_799", col_a, 10'd799);
        cycle();
        chk10("line.wrap_Colpx", col_a, 10'd0);
        chk10("line.wrap_Rowpx", row_a, 10'd1);
        chki("line.hsync_low_clocks", h_low, 96);
        chki("line.hsync_first_col", h_first, DLY ? 658 : 656);
        chki("line.video_on_clocks", v_on, 640);
        chki("line.video_on_first_col", v_first, DLY ? 2 : 0);

        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0;
        cycle();
        v_low = 0; v_fst = -1; v_row = -1; ft_n = 0; ft_idx = -1;
        wrap_idx = -1; wpc = -1; wpr = -1; wde = 1'bx;
        ftc = '1; ftr = '1; ftc_ok = 1'b0;
        for (int k = 1; k <= 475; k++) begin
            pc = int'(col_b);
            pr = int'(row_b);
            cycle();
            if (!vs_b) begin
                if (v_fst < 0) begin
                    v_fst = k;
                    v_row = int'(row_b);
                end
                v_low++;
            end
            if (ft_b) begin
                ft_n++;
                ft_idx = k;
                ftc = col_b;
                ftr = row_b;
                ftc_ok = 1'b1;
            end
            if (col_b == 10'd0 && row_b == 10'd0 && wrap_idx < 0) begin
                wrap_idx = k;
                wpc = pc;
                wpr = pr;
                wde = de_b;
            end
        end
        chki("frame.vsync_low_clocks", v_low, 50);
        chki("frame.vsync_first_row", v_row, 14);
        chki("frame.tick_count", ft_n, 1);
        chk1("frame.tick_seen", ftc_ok, 1'b1);
        chk10("frame.tick_col", ftc, 10'd0);
        chk10("frame.tick_row", ftr, 10'd12);
        chki("frame.tick_index", ft_idx, 300);
        chki("frame.tick_to_vsync", v_fst - ft_idx, DLY ? 52 : 50);
        chki("frame.period", wrap_idx, 475);
        chki("frame.wrap_prev_col", wpc, 24);
        chki("frame.wrap_prev_row", wpr, 18);
        chk1("frame.wrap_video_on", wde, DLY ? 1'b0 : 1'b1);

        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (col_b == 10'd19 && row_b == 10'd15) found = 1'b1;
            else cycle();
        end
        chk1("b.reach_mid_frame", found, 1'b1);
        chk1("b.mid_hsync", hs_b, DLY ? 1'b1 : 1'b0);
        chk1("b.mid_vsync", vs_b, 1'b0);
        rst_b = 1'b1;
        cycle();
        chk10("b.mrst_Colpx", col_b, 10'd0);
        chk10("b.mrst_Rowpx", row_b, 10'd0);
        chk1("b.mrst_hsync", hs_b, 1'b1);
        chk1("b.mrst_vsync", vs_b, 1'b1);
        chk1("b.mrst_video_on", de_b, 1'b0);
        chk1("b.mrst_frame_tick", ft_b, 1'b0);
        rst_b = 1'b0;
        repeat (2) cycle();

        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (col_a == 10'd700) found = 1'b1;
            else cycle();
        end
        chk1("a.reach_col700", found, 1'b1);
        chk1("a.col700_hsync", hs_a, 1'b0);
        rst_a = 1'b1;
        cycle();
        chk10("a.mrst_Colpx", col_a, 10'd0);
        chk10("a.mrst_Rowpx", row_a, 10'd0);
        chk1("a.mrst_hsync", hs_a, 1'b1);
        chk1("a.mrst_video_on", de_a, 1'b0);
        rst_a = 1'b0;
        repeat (3) cycle();
        chk10("a.post_Colpx", col_a, 10'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
